// File: rtl/fault_detect_mc_if.sv
// Stream/verdict bundle for the multi-channel band-metric fault detector.
// The bench drives through master; the detector attaches as slave.
interface fault_detect_mc_if #(
  parameter int AMP_W = 32,
  parameter int N_BIN = 512,
  parameter int N_CH  = 4
) ();
  localparam int BIN_W = $clog2(N_BIN);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W = AMP_W + BIN_W;

  logic [AMP_W-1:0] amp_i;
  logic             amp_vaild_i;
  logic [CH_W-1:0]  ch_i;
  logic             sof_i;
  logic [BIN_W-1:0] band_lo_i;
  logic [BIN_W-1:0] band_hi_i;
  logic [ACC_W-1:0] thresh_i;
  logic             mode_i;
  logic             fault_detected_o;
  logic             vaild_o;
  logic [CH_W-1:0]  fault_ch_o;
  logic [ACC_W-1:0] metric_o;
  logic             overrun_o;

  modport master (
    output amp_i, amp_vaild_i, ch_i, sof_i, band_lo_i, band_hi_i, thresh_i, mode_i,
    input  fault_detected_o, vaild_o, fault_ch_o, metric_o, overrun_o
  );

  modport slave (
    input  amp_i, amp_vaild_i, ch_i, sof_i, band_lo_i, band_hi_i, thresh_i, mode_i,
    output fault_detected_o, vaild_o, fault_ch_o, metric_o, overrun_o
  );
endinterface

// File: rtl/fault_detect_mc.sv
// Multi-channel band energy/peak fault detector: per-channel frame FSM reduces
// a bin band to one metric and issues a registered, channel-tagged verdict.
module fault_detect_mc #(
  parameter int AMP_W = 32,
  parameter int N_BIN = 512,
  parameter int N_CH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fault_detect_mc_if.slave bus
);
  localparam int BIN_W = $clog2(N_BIN);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W = AMP_W + BIN_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q  [N_CH];
  state_t           state_d  [N_CH];
  logic [BIN_W-1:0] bin_q    [N_CH];
  logic [BIN_W-1:0] bin_d    [N_CH];
  logic [ACC_W-1:0] acc_q    [N_CH];
  logic [ACC_W-1:0] acc_d    [N_CH];
  logic [BIN_W-1:0] lo_q     [N_CH];
  logic [BIN_W-1:0] lo_d     [N_CH];
  logic [BIN_W-1:0] hi_q     [N_CH];
  logic [BIN_W-1:0] hi_d     [N_CH];
  logic [ACC_W-1:0] thresh_q [N_CH];
  logic [ACC_W-1:0] thresh_d [N_CH];
  logic             mode_q   [N_CH];
  logic             mode_d   [N_CH];

  logic             ready_q;
  logic             beat_ok;
  logic [BIN_W-1:0] bin_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             verdict_d;
  logic             overrun_d;
  logic             fault_d;
  logic [ACC_W-1:0] metric_d;
  logic [CH_W-1:0]  ch_d;

  function automatic logic [ACC_W-1:0] contrib(
    input logic [ACC_W-1:0] acc,
    input logic [AMP_W-1:0] amp,
    input logic [BIN_W-1:0] bin,
    input logic [BIN_W-1:0] lo,
    input logic [BIN_W-1:0] hi,
    input logic             mode
  );
    logic [ACC_W-1:0] ext;
    ext     = ACC_W'(amp);
    contrib = acc;
    if ((bin >= lo) && (bin <= hi))
      contrib = mode ? ((ext > acc) ? ext : acc) : (acc + ext);
  endfunction

  // ready_q blocks beats on the first edge after reset release
  assign beat_ok = ready_q && bus.amp_vaild_i;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    thresh_d  = thresh_q;
    mode_d    = mode_q;
    bin_nxt   = '0;
    acc_nxt   = '0;
    verdict_d = 1'b0;
    overrun_d = 1'b0;
    fault_d   = 1'b0;
    metric_d  = '0;
    ch_d      = '0;
    // Only channel ids below N_CH can match, so out-of-range beats fall through
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (beat_ok && (bus.ch_i == CH_W'(c))) begin
        if (bus.sof_i) begin
          overrun_d   = (state_q[c] == ACCUM);
          state_d[c]  = ACCUM;
          bin_d[c]    = '0;
          lo_d[c]     = bus.band_lo_i;
          hi_d[c]     = bus.band_hi_i;
          thresh_d[c] = bus.thresh_i;
          mode_d[c]   = bus.mode_i;
          acc_d[c]    = contrib('0, bus.amp_i, '0, bus.band_lo_i, bus.band_hi_i, bus.mode_i);
        end else if (state_q[c] == ACCUM) begin
          bin_nxt = bin_q[c] + 1'b1;
          acc_nxt = contrib(acc_q[c], bus.amp_i, bin_nxt, lo_q[c], hi_q[c], mode_q[c]);
          if (bin_nxt == BIN_W'(N_BIN - 1)) begin
            verdict_d  = 1'b1;
            metric_d   = acc_nxt;
            fault_d    = (acc_nxt > thresh_q[c]);
            ch_d       = CH_W'(c);
            state_d[c] = IDLE;
            bin_d[c]   = '0;
            acc_d[c]   = '0;
          end else begin
            bin_d[c] = bin_nxt;
            acc_d[c] = acc_nxt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        state_q[c]  <= IDLE;
        bin_q[c]    <= '0;
        acc_q[c]    <= '0;
        lo_q[c]     <= '0;
        hi_q[c]     <= '0;
        thresh_q[c] <= '0;
        mode_q[c]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      thresh_q <= thresh_d;
      mode_q   <= mode_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q              <= 1'b0;
      bus.vaild_o          <= 1'b0;
      bus.overrun_o        <= 1'b0;
      bus.fault_detected_o <= 1'b0;
      bus.metric_o         <= '0;
      bus.fault_ch_o       <= '0;
    end else begin
      ready_q       <= 1'b1;
      bus.vaild_o   <= verdict_d;
      bus.overrun_o <= overrun_d;
      if (verdict_d) begin
        bus.fault_detected_o <= fault_d;
        bus.metric_o         <= metric_d;
        bus.fault_ch_o       <= ch_d;
      end
    end
  end
endmodule

// File: tb/tb_fault_detect_mc.sv
// Scoreboard bench for fault_detect_mc: directed frames push expected verdicts
// and overrun cycles; a forked monitor pops and compares on each DUT strobe.
module tb_fault_detect_mc;
  localparam int AMP_W = 16;
  localparam int N_BIN = 8;
  localparam int N_CH  = 4;

  typedef struct {
    int ch;
    int metric;
    bit fault;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_i;
  int   cyc;
  int   last_cyc;
  int   checks;
  int   passed;
  exp_t exp_q[$];
  int   ov_q[$];

  fault_detect_mc_if #(.AMP_W(AMP_W), .N_BIN(N_BIN), .N_CH(N_CH)) bus ();

  fault_detect_mc #(.AMP_W(AMP_W), .N_BIN(N_BIN), .N_CH(N_CH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic monitor();
    exp_t e;
    int   o;
    forever begin
      @(negedge clk);
      if (bus.vaild_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_verdict", int'(bus.metric_o), -1);
        end else begin
          e = exp_q.pop_front();
          check("verdict_ch",     int'(bus.fault_ch_o),       e.ch);
          check("verdict_metric", int'(bus.metric_o),         e.metric);
          check("verdict_fault",  int'(bus.fault_detected_o), int'(e.fault));
          check("verdict_cycle",  cyc,                        e.cyc);
        end
      end
      if (bus.overrun_o) begin
        if (ov_q.size() == 0) begin
          check("unexpected_overrun", cyc, -1);
        end else begin
          o = ov_q.pop_front();
          check("overrun_cycle", cyc, o);
        end
      end
    end
  endtask

  task automatic beat(input int ch, input bit sof, input int amp, input bit vld = 1'b1);
    bus.ch_i        = ch[1:0];
    bus.sof_i       = sof;
    bus.amp_i       = AMP_W'(amp);
    bus.amp_vaild_i = vld;
    @(posedge clk);
    #1;
    last_cyc        = cyc;
    bus.amp_vaild_i = 1'b0;
    bus.sof_i       = 1'b0;
  endtask

  task automatic cfg(input int lo, input int hi, input int thr, input bit mode);
    bus.band_lo_i = 3'(lo);
    bus.band_hi_i = 3'(hi);
    bus.thresh_i  = 19'(thr);
    bus.mode_i    = mode;
  endtask

  task automatic expect_v(input int ch, input int metric, input bit fault);
    exp_q.push_back('{ch, metric, fault, last_cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit %0d", $time, 200000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int amps2[8];
    amps2 = '{3, 90, 4, 7, 1, 1, 1, 1};
    checks = 0;
    passed = 0;
    bus.amp_i = '0; bus.amp_vaild_i = 1'b0; bus.ch_i = '0; bus.sof_i = 1'b0;
    cfg(0, 7, 0, 1'b0);
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("reset_outputs",
          int'({bus.vaild_o, bus.overrun_o, bus.fault_detected_o, bus.fault_ch_o, bus.metric_o}), 0);
    fork
      monitor();
    join_none
    @(posedge clk); @(posedge clk);
    #1 rst_i = 1'b1;
    idle(2);

    // 1: sum band 2..4, amps = bin index
    cfg(2, 4, 8, 1'b0);
    for (int b = 0; b < 8; b++) beat(0, b == 0, b);
    expect_v(0, 9, 1'b1);
    cfg(2, 4, 9, 1'b0);
    for (int b = 0; b < 8; b++) beat(0, b == 0, b);
    expect_v(0, 9, 1'b0);
    idle(2);

    // 2: peak over full band
    cfg(0, 7, 89, 1'b1);
    for (int b = 0; b < 8; b++) beat(0, b == 0, amps2[b]);
    expect_v(0, 90, 1'b1);
    idle(2);

    // 3: four channels round-robin, amp = ch+1
    cfg(0, 7, 20, 1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 4; c++) begin
        beat(c, b == 0, c + 1);
        if (b == 7) expect_v(c, 8 * (c + 1), (8 * (c + 1)) > 20);
      end
    idle(2);

    // 4: early sof on channel 2 at bin 5
    cfg(0, 7, 40, 1'b0);
    for (int b = 0; b < 5; b++) beat(2, b == 0, 100);
    beat(2, 1'b1, 1);
    ov_q.push_back(last_cyc);
    for (int b = 1; b < 8; b++) beat(2, 1'b0, b + 1);
    expect_v(2, 36, 1'b0);
    idle(2);

    // 5: empty band, then mid-frame config change
    cfg(6, 1, 0, 1'b0);
    for (int b = 0; b < 8; b++) beat(0, b == 0, 1000);
    expect_v(0, 0, 1'b0);
    cfg(0, 7, 0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      beat(1, b == 0, 5);
      if (b == 3) cfg(6, 1, 1000, 1'b1);
    end
    expect_v(1, 40, 1'b1);
    idle(2);

    // 6: async reset with a verdict live and channel 1 mid-frame
    cfg(0, 7, 0, 1'b0);
    for (int b = 0; b < 4; b++) beat(1, b == 0, 7);
    for (int b = 0; b < 8; b++) beat(3, b == 0, 9);
    #1 rst_i = 1'b0;
    #1;
    check("midframe_reset_outputs",
          int'({bus.vaild_o, bus.overrun_o, bus.fault_detected_o, bus.fault_ch_o, bus.metric_o}), 0);
    idle(2);
    rst_i = 1'b1;
    for (int b = 0; b < 8; b++) beat(1, 1'b0, 50);
    idle(2);
    cfg(2, 5, 179, 1'b0);
    for (int b = 0; b < 8; b++) begin
      beat(1, b == 0, 10 * (b + 1));
      if (b < 7) beat(1, 1'b1, 999, 1'b0);
    end
    expect_v(1, 180, 1'b1);
    idle(4);

    check("pending_verdicts", exp_q.size(), 0);
    check("pending_overruns", ov_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fault_detect_mc.md
Name: fault_detect_mc

Overview:
Parametrised multi-channel successor to the single-channel magnetic-tile fault detector. It sits directly after the FFT amplitude stage and accepts an interleaved per-bin amplitude stream tagged with a channel number. Per channel, it reduces a programmable frequency band to one metric, either band energy (sum) or band peak (max). At each frame end it compares that metric against a threshold and issues a one-cycle verdict tagged with the channel.

Parameters:
AMP_W, 32, amplitude input width (unsigned)
N_BIN, 512, bins per frame; power of two, >= 4
N_CH, 4, number of independent channels, >= 1
BIN_W, $clog2(N_BIN), bin index width (derived)
CH_W, max(1,$clog2(N_CH)), channel id width (derived)
ACC_W, AMP_W+BIN_W, metric/accumulator width (derived; sum cannot overflow)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-low
amp_i  in  AMP_W  bin amplitude
amp_vaild_i  in  1  amp_i/ch_i/sof_i valid this cycle
ch_i  in  CH_W  channel of current beat
sof_i  in  1  qualifies beat as bin 0 of a new frame for ch_i
band_lo_i  in  BIN_W  first bin of band, inclusive
band_hi_i  in  BIN_W  last bin of band, inclusive
thresh_i  in  ACC_W  fault threshold
mode_i  in  1  0 = band sum, 1 = band peak
fault_detected_o  out  1  metric > threshold; meaningful only with vaild_o
vaild_o  out  1  one-cycle verdict strobe
fault_ch_o  out  CH_W  channel of verdict
metric_o  out  ACC_W  final metric of verdict frame
overrun_o  out  1  one-cycle pulse: frame on channel aborted by early sof_i

Behaviour:
- Reset (rst_i=0, async): all outputs 0; every channel returns to IDLE with bin counter 0, accumulator 0 and latched config cleared. Release is synchronous to clk_i; no beat is accepted in the reset-release cycle itself.
- Each channel has its own FSM with states IDLE and ACCUM, plus a bin counter, accumulator and latched config (band_lo, band_hi, thresh, mode).
- Beats with amp_vaild_i=0 are ignored. Beats with ch_i >= N_CH are dropped with no state change.
- IDLE: a beat with sof_i=1 latches config from the ports, treats the beat as bin 0 and moves to ACCUM. A beat with sof_i=0 is dropped.
- ACCUM, sof_i=0: bin counter increments. The beat contributes if band_lo <= bin <= band_hi, using the latched config. In sum mode it adds amp_i, zero-extended to ACC_W. In peak mode the accumulator becomes max(acc, amp_i).
- ACCUM, sof_i=1 (early sof): the partial frame is discarded, overrun_o pulses next cycle, and the new frame starts exactly as from IDLE. No verdict is issued for the aborted frame.
- Frame end is the beat at bin N_BIN-1. That beat's contribution is included, and the channel returns to IDLE.
- Verdict is registered with latency 1: on the cycle after the last-bin beat, vaild_o=1, fault_ch_o=ch, metric_o=final metric and fault_detected_o=(metric > thresh), a strict compare.
- Only one beat arrives per cycle, so at most one verdict and at most one overrun occur per cycle. They are mutually exclusive because a bin N_BIN-1 beat cannot carry sof_i.
- Config ports can change at any time. They affect only frames starting after the change.
- band_lo > band_hi: empty band; metric 0; fault_detected_o=0 for any thresh.
- Channels are fully independent. Arbitrary interleaving of ch_i values is legal.
- Peak mode with an all-zero band gives metric 0.
- Reset asserted mid-frame: the frame is lost and no verdict or overrun is issued.

Test Plan:
1. N_CH=1, N_BIN=8, sum mode, band 2..4, amps = bin index (0..7), thresh=8 -> one verdict, vaild_o 1 cycle after bin-7 beat, metric_o=9, fault_detected_o=1, fault_ch_o=0; repeat with thresh=9 -> fault_detected_o=0.
2. Peak mode, band 0..7, amps {3,90,4,7,1,1,1,1}, thresh=89 -> metric_o=90, fault=1.
3. N_CH=4, four frames interleaved round-robin, amp=ch+1 on all bins, full band, sum mode -> four verdicts in channel order 0..3, metrics 8,16,24,32.
4. Channel 2 gets sof_i at bin 5 of an active frame -> overrun_o pulses once; no verdict for the old frame; new frame completes 8 beats later with correct metric.
5. band_lo=6, band_hi=1, thresh=0, large amps -> metric_o=0, fault=0. Change band ports mid-frame -> current frame unaffected.
6. Assert rst_i low asynchronously mid-frame -> all outputs 0 immediately. Beats without sof_i after release are dropped; next sof_i frame verdicts correctly. amp_vaild_i gaps inside frames do not alter metrics.
